// File: rtl/ppu_mem_arbiter.sv
// VRAM/OAM port arbiter between CPU, PPU and the OAM DMA engine (trigger: write to 0xFF46).
// Grant is purely combinational from ppu_mode/lcd_on; only the DMA engine holds state.
module ppu_mem_arbiter #(
  parameter int DMA_BYTES    = 160,
  parameter int CYC_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_rd,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic        dma_active
);

  localparam int PW = (CYC_PER_BYTE > 2) ? $clog2(CYC_PER_BYTE) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CYC_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(DMA_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} dma_state_t;

  dma_state_t    r_state;
  logic [7:0]    r_page;
  logic [7:0]    r_idx;
  logic [PW-1:0] r_phase;
  logic [7:0]    r_byte;

  logic       w_ff46_wr;
  logic       w_dma_rd;
  logic       w_dma_wr;
  logic [7:0] w_eff_page;
  logic       w_cpu_vram;
  logic       w_cpu_oam;
  logic       w_ppu_vram;
  logic       w_ppu_oam;
  logic       w_ppu_owns_vram;
  logic       w_ppu_owns_oam;

  assign w_ff46_wr  = cpu_wr && (cpu_addr == 16'hFF46);
  assign w_dma_rd   = (r_state == S_XFER) && (r_phase == '0);
  assign w_dma_wr   = (r_state == S_XFER) && (r_phase == PH_LAST);
  // Echo RAM (0xE000-0xFDFF) mirrors WRAM, so those pages fold down by 0x20.
  assign w_eff_page = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;
  assign dma_active = (r_state != S_IDLE);

  assign w_cpu_vram = (cpu_addr[15:13] == 3'b100);
  assign w_cpu_oam  = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
  assign w_ppu_vram = (ppu_addr[15:13] == 3'b100);
  assign w_ppu_oam  = (ppu_addr >= 16'hFE00) && (ppu_addr <= 16'hFE9F);

  assign w_ppu_owns_vram = lcd_on && (ppu_mode == 2'd3);
  assign w_ppu_owns_oam  = lcd_on && ppu_mode[1];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_idx   <= 8'h00;
      r_phase <= '0;
      r_byte  <= 8'h00;
    end else if (w_ff46_wr) begin
      // A rewrite restarts from byte 0; any OAM write this cycle still lands.
      r_page  <= cpu_wdata;
      r_state <= S_START;
      r_idx   <= 8'h00;
      r_phase <= '0;
    end else begin
      case (r_state)
        S_START: begin
          r_state <= S_XFER;
          r_phase <= '0;
        end
        S_XFER: begin
          if (w_dma_rd) r_byte <= src_rdata;
          if (w_dma_wr) begin
            r_phase <= '0;
            r_idx   <= r_idx + 8'd1;
            if (r_idx == IDX_LAST) r_state <= S_IDLE;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    src_rd     = w_dma_rd;
    src_addr   = w_dma_rd ? {w_eff_page, r_idx} : 16'h0000;
    vram_addr  = 13'h0000;
    vram_rd    = 1'b0;
    vram_wr    = 1'b0;
    vram_wdata = 8'h00;
    oam_addr   = 8'h00;
    oam_rd     = 1'b0;
    oam_wr     = 1'b0;
    oam_wdata  = 8'h00;
    cpu_rdata  = 8'hFF;
    ppu_rdata  = 8'hFF;

    if (w_ppu_owns_vram) begin
      if (ppu_rd && w_ppu_vram) begin
        vram_rd   = 1'b1;
        vram_addr = ppu_addr[12:0];
        ppu_rdata = vram_rdata;
      end
    end else if (w_cpu_vram && (cpu_rd || cpu_wr)) begin
      vram_addr  = cpu_addr[12:0];
      vram_rd    = cpu_rd;
      vram_wr    = cpu_wr;
      vram_wdata = cpu_wr ? cpu_wdata : 8'h00;
      if (cpu_rd) cpu_rdata = vram_rdata;
    end

    // DMA locks out both other requesters for its whole run, even in idle phases.
    if (dma_active) begin
      if (w_dma_wr) begin
        oam_wr    = 1'b1;
        oam_addr  = r_idx;
        oam_wdata = r_byte;
      end
    end else if (w_ppu_owns_oam) begin
      if (ppu_rd && w_ppu_oam) begin
        oam_rd    = 1'b1;
        oam_addr  = ppu_addr[7:0];
        ppu_rdata = oam_rdata;
      end
    end else if (w_cpu_oam && (cpu_rd || cpu_wr)) begin
      oam_addr  = cpu_addr[7:0];
      oam_rd    = cpu_rd;
      oam_wr    = cpu_wr;
      oam_wdata = cpu_wr ? cpu_wdata : 8'h00;
      if (cpu_rd) cpu_rdata = oam_rdata;
    end

    if (cpu_addr == 16'hFF46) cpu_rdata = r_page;
  end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Bench for ppu_mem_arbiter: directed scenarios plus random CPU/PPU/DMA traffic,
// checked by a monitor against queues filled by a transaction-level model.
module tb_ppu_mem_arbiter;

  localparam int DMA_BYTES = 160;
  localparam int CYC       = 4;
  localparam int DMA_CYC   = 1 + DMA_BYTES * CYC;

  logic        clk;
  logic        rstN;
  logic        lcd_on;
  logic [1:0]  ppu_mode;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        ppu_rd;
  logic [15:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        src_rd;
  logic [15:0] src_addr;
  logic [7:0]  src_rdata;
  logic [12:0] vram_addr;
  logic        vram_rd;
  logic        vram_wr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_rd;
  logic        oam_wr;
  logic [7:0]  oam_wdata;
  logic [7:0]  oam_rdata;
  logic        dma_active;

  ppu_mem_arbiter #(.DMA_BYTES(DMA_BYTES), .CYC_PER_BYTE(CYC)) dut (
    .clk(clk), .rstN(rstN), .lcd_on(lcd_on), .ppu_mode(ppu_mode),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .ppu_rd(ppu_rd), .ppu_addr(ppu_addr), .ppu_rdata(ppu_rdata),
    .src_rd(src_rd), .src_addr(src_addr), .src_rdata(src_rdata),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .oam_addr(oam_addr), .oam_rd(oam_rd), .oam_wr(oam_wr),
    .oam_wdata(oam_wdata), .oam_rdata(oam_rdata), .dma_active(dma_active)
  );

  // ---------------- clock / reset / environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_pat(input int a);
    return 8'((a * 37 + 11) ^ (a >> 5));
  endfunction

  logic [7:0] vram_mem [8192];
  logic [7:0] oam_mem  [256];
  logic       filled = 1'b0;
  logic [7:0] src_key = 8'h00;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 8192; i++) vram_mem[i] <= init_pat(i);
      for (int i = 0; i < 256; i++) oam_mem[i] <= init_pat(i + 8192);
      filled <= 1'b1;
    end else begin
      if (vram_wr) vram_mem[vram_addr] <= vram_wdata;
      if (oam_wr) oam_mem[oam_addr] <= oam_wdata;
    end
  end

  assign vram_rdata = vram_mem[vram_addr];
  assign oam_rdata  = oam_mem[oam_addr];
  assign src_rdata  = src_addr[7:0] ^ src_key;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];       // OAM writes {addr, data}
  logic [15:0] exp_src_q[$];   // DMA source reads
  logic [20:0] exp_vram_q[$];  // VRAM writes {addr, data}
  logic [9:0]  exp_rd_q[$];    // reads {vram_rd, oam_rd, rdata}

  logic [7:0] ref_vram [8192];
  logic [7:0] ref_oam  [256];
  logic [7:0] m_page = 8'h00;
  logic [7:0] m_key  = 8'h00;
  bit         armed  = 1'b0;
  int         t0     = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] eff(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  function automatic bit is_oam(input logic [15:0] a);
    return (a >= 16'hFE00) && (a <= 16'hFE9F);
  endfunction

  // Interval number within the current transfer: 1 = START, 2.. = transfer cycles.
  function automatic int cur_k();
    return cyc - t0 + 1;
  endfunction

  function automatic bit m_dma();
    return armed && (cur_k() <= DMA_CYC);
  endfunction

  task automatic model_trigger(input logic [7:0] p);
    m_page = p;
    m_key  = src_key;
    armed  = 1'b1;
    for (int i = 0; i < DMA_BYTES; i++) begin
      exp_src_q.push_back({eff(p), 8'(i)});
      exp_q.push_back({8'(i), 8'(i) ^ src_key});
    end
  endtask

  // The transfer stops after n intervals: byte i is read in interval 2+i*CYC and
  // written in interval (i+1)*CYC+1; anything later never happens.
  task automatic model_close(input int n);
    int w;
    int s;
    w = (n >= 1) ? (n - 1) / CYC : 0;
    if (w > DMA_BYTES) w = DMA_BYTES;
    s = (n >= 2) ? (n - 2) / CYC + 1 : 0;
    if (s > DMA_BYTES) s = DMA_BYTES;
    repeat (DMA_BYTES - w) if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (DMA_BYTES - s) if (exp_src_q.size() > 0) void'(exp_src_q.pop_back());
    for (int i = 0; i < w; i++) ref_oam[i] = 8'(i) ^ m_key;
    armed = 1'b0;
  endtask

  task automatic model_lazy();
    if (armed && cur_k() > DMA_CYC) model_close(DMA_CYC);
  endtask

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int k);
    while (cur_k() < k) idle(1);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    bit trig;
    model_lazy();
    trig = (a == 16'hFF46);
    if (trig) begin
      if (m_dma()) model_close(cur_k());
      model_trigger(d);
    end else if (a[15:13] == 3'b100) begin
      if (!(lcd_on && ppu_mode == 2'd3)) begin
        exp_vram_q.push_back({a[12:0], d});
        ref_vram[a[12:0]] = d;
      end
    end else if (is_oam(a)) begin
      if (!m_dma() && !(lcd_on && ppu_mode[1])) begin
        exp_q.push_back({a[7:0], d});
        ref_oam[a[7:0]] = d;
      end
    end
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
    @(posedge clk);
    #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    if (trig) t0 = cyc;
  endtask

  task automatic cpu_read(input logic [15:0] a);
    logic [9:0] e;
    model_lazy();
    e = {2'b00, 8'hFF};
    if (a == 16'hFF46) e = {2'b00, m_page};
    else if (a[15:13] == 3'b100) begin
      if (!(lcd_on && ppu_mode == 2'd3)) e = {2'b10, ref_vram[a[12:0]]};
    end else if (is_oam(a)) begin
      if (!m_dma() && !(lcd_on && ppu_mode[1])) e = {2'b01, ref_oam[a[7:0]]};
    end
    exp_rd_q.push_back(e);
    cpu_addr = a; cpu_rd = 1'b1;
    @(posedge clk);
    #1;
    cpu_rd = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic ppu_read(input logic [15:0] a);
    logic [9:0] e;
    model_lazy();
    e = {2'b00, 8'hFF};
    if (a[15:13] == 3'b100) begin
      if (lcd_on && ppu_mode == 2'd3) e = {2'b10, ref_vram[a[12:0]]};
    end else if (is_oam(a)) begin
      if (!m_dma() && lcd_on && ppu_mode[1]) e = {2'b01, ref_oam[a[7:0]]};
    end
    exp_rd_q.push_back(e);
    ppu_addr = a; ppu_rd = 1'b1;
    @(posedge clk);
    #1;
    ppu_rd = 1'b0; ppu_addr = 16'h0000;
  endtask

  function automatic logic [15:0] rand_addr(input bit for_write);
    logic [15:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: a = 16'h8000 + 16'($urandom_range(0, 8191));
      4, 5, 6:    a = 16'hFE00 + 16'($urandom_range(0, 159));
      7:          a = 16'hFEA0 + 16'($urandom_range(0, 95));
      8:          a = for_write ? 16'hC000 + 16'($urandom_range(0, 255)) : 16'hFF46;
      default: begin
        a = 16'($urandom);
        if (for_write && a == 16'hFF46) a = 16'hFF47;
      end
    endcase
    return a;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstN) begin
      if (oam_wr) begin
        if (exp_q.size() == 0) check("oam_wr_unexpected", {oam_addr, oam_wdata}, 32'hFFFF_FFFF);
        else check("oam_wr", {oam_addr, oam_wdata}, exp_q.pop_front());
      end
      if (vram_wr) begin
        if (exp_vram_q.size() == 0) check("vram_wr_unexpected", {vram_addr, vram_wdata}, 32'hFFFF_FFFF);
        else check("vram_wr", {vram_addr, vram_wdata}, exp_vram_q.pop_front());
      end
      if (src_rd) begin
        if (exp_src_q.size() == 0) check("src_rd_unexpected", src_addr, 32'hFFFF_FFFF);
        else check("src_addr", src_addr, exp_src_q.pop_front());
      end
      if (cpu_rd || ppu_rd) begin
        if (exp_rd_q.size() == 0) check("read_unexpected", {vram_rd, oam_rd, cpu_rdata}, 32'hFFFF_FFFF);
        else if (cpu_rd) check("cpu_read", {vram_rd, oam_rd, cpu_rdata}, exp_rd_q.pop_front());
        else check("ppu_read", {vram_rd, oam_rd, ppu_rdata}, exp_rd_q.pop_front());
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int r;
    logic [7:0] p;
    for (int i = 0; i < 8192; i++) ref_vram[i] = init_pat(i);
    for (int i = 0; i < 256; i++) ref_oam[i] = init_pat(i + 8192);
    rstN = 1'b0; lcd_on = 1'b0; ppu_mode = 2'd0;
    cpu_addr = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
    ppu_addr = 16'h0000; ppu_rd = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {dma_active, src_rd, vram_rd, vram_wr, oam_rd, oam_wr}, 0);
    check("reset_addrs", {src_addr, vram_addr, oam_addr}, 0);
    check("reset_wdata", {vram_wdata, oam_wdata}, 0);
    check("reset_cpu_rdata", cpu_rdata, 8'hFF);
    rstN = 1'b1;
    idle(1);

    // LCD off: CPU owns both RAMs
    cpu_write(16'h8010, 8'h5A);
    cpu_read(16'h8010);
    cpu_write(16'hFE05, 8'h3C);
    cpu_read(16'hFE05);
    cpu_write(16'hFEA5, 8'h11);
    cpu_read(16'hFEA5);
    cpu_read(16'hFF46);

    // Mode 3: PPU owns both
    lcd_on = 1'b1; ppu_mode = 2'd3;
    cpu_read(16'h9800);
    cpu_read(16'hFE00);
    cpu_write(16'h9800, 8'h99);
    ppu_read(16'h9800);
    ppu_read(16'hFE00);
    ppu_mode = 2'd2;
    ppu_read(16'h9800);
    cpu_read(16'h9801);
    lcd_on = 1'b0; ppu_mode = 2'd0;

    // Plain DMA from 0xC100, source data = low address byte
    src_key = 8'h00;
    cpu_write(16'hFF46, 8'hC1);
    n = 0;
    while (dma_active === 1'b1 && n < 800) begin
      n++;
      idle(1);
    end
    check("dma_active_cycles", n, DMA_CYC);
    cpu_read(16'hFF46);
    cpu_read(16'hFE10);
    cpu_read(16'hFE9F);

    // DMA from echo page 0xFE, lockout checks, restart at byte 50
    cpu_write(16'hFF46, 8'hFE);
    wait_to(20);
    lcd_on = 1'b1; ppu_mode = 2'd2;
    cpu_read(16'hFE10);
    ppu_read(16'hFE20);
    cpu_write(16'hFE30, 8'h77);
    lcd_on = 1'b0; ppu_mode = 2'd0;
    cpu_read(16'hFE11);
    wait_to(50 * CYC + 3);
    cpu_write(16'hFF46, 8'h80);
    wait_to(DMA_CYC + 2);
    cpu_read(16'hFE31);
    cpu_read(16'hFF46);

    // Reset in the middle of a transfer at byte 100
    src_key = 8'h5A;
    cpu_write(16'hFF46, 8'hC3);
    wait_to(100 * CYC + 3);
    check("dma_active_before_reset", dma_active, 1'b1);
    rstN = 1'b0;
    #1;
    check("abort_strobes", {dma_active, src_rd, oam_wr}, 0);
    if (m_dma()) model_close(cur_k() - 1);
    m_page = 8'h00;
    idle(2);
    rstN = 1'b1;
    idle(DMA_CYC + 20);
    check("abort_oam_left", exp_q.size(), 0);
    check("abort_src_left", exp_src_q.size(), 0);
    cpu_read(16'hFF46);
    cpu_read(16'hFE63);
    cpu_read(16'hFE64);

    // Random traffic
    src_key = 8'($urandom);
    for (int it = 0; it < 2500; it++) begin
      lcd_on   = 1'($urandom_range(0, 1));
      ppu_mode = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 99);
      if (r < 3) begin
        p = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(224, 255)) : 8'($urandom);
        cpu_write(16'hFF46, p);
      end else if (r < 25) cpu_write(rand_addr(1'b1), 8'($urandom));
      else if (r < 50) cpu_read(rand_addr(1'b0));
      else if (r < 75) ppu_read(rand_addr(1'b0));
      else idle(1);
    end

    lcd_on = 1'b0; ppu_mode = 2'd0;
    n = 0;
    while (m_dma() && n < 2 * DMA_CYC) begin
      n++;
      idle(1);
    end
    idle(2);
    for (int i = 0; i < DMA_BYTES; i++) cpu_read(16'hFE00 + 16'(i));
    for (int i = 0; i < 64; i++) cpu_read(16'h8000 + 16'($urandom_range(0, 8191)));
    idle(2);
    check("final_oam_q", exp_q.size(), 0);
    check("final_src_q", exp_src_q.size(), 0);
    check("final_vram_q", exp_vram_q.size(), 0);
    check("final_rd_q", exp_rd_q.size(), 0);
    check("final_dma_idle", dma_active, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_mem_arbiter.md
Name: ppu_mem_arbiter

Overview:
- Owns the VRAM (0x8000–0x9FFF) and OAM (0xFE00–0xFE9F) ports.
- Arbitrates them between the CPU, the PPU pixel/OAM-scan engine and an internal OAM DMA engine, which is triggered by writes to 0xFF46.
- Access rules follow the PPU mode: CPU is locked out of OAM in modes 2/3 and out of VRAM in mode 3. DMA always owns OAM while active.
- Sits between the CPU MMIO bus, the PPU's PPU_ADDR/PPU_RD port and the two video RAMs.

Parameters:
- DMA_BYTES, 160, number of bytes copied per DMA transfer.
- CYC_PER_BYTE, 4, clocks per DMA byte (one M-cycle); must be ≥2.

Ports:
- clk  in  1  clock
- rstN  in  1  reset
- lcd_on  in  1  LCDC[7]; 0 = PPU idle, CPU owns VRAM/OAM (DMA rules still apply)
- ppu_mode  in  2  0=HBLANK 1=VBLANK 2=SCAN 3=DRAW
- cpu_addr  in  16  CPU address
- cpu_rd  in  1  CPU read strobe
- cpu_wr  in  1  CPU write strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data for VRAM/OAM/FF46 addresses, else 0xFF
- ppu_rd  in  1  PPU read strobe
- ppu_addr  in  16  PPU address
- ppu_rdata  out  8  PPU read data
- src_rd  out  1  DMA source read strobe
- src_addr  out  16  DMA source address
- src_rdata  in  8  DMA source data, combinational, same cycle
- vram_addr  out  13  VRAM offset
- vram_rd  out  1  VRAM read strobe
- vram_wr  out  1  VRAM write strobe
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM data, combinational
- oam_addr  out  8  OAM offset
- oam_rd  out  1  OAM read strobe
- oam_wr  out  1  OAM write strobe
- oam_wdata  out  8  OAM write data
- oam_rdata  in  8  OAM data, combinational
- dma_active  out  1  DMA transfer in progress

Behaviour:
- Reset: clk, with reset rstN, asynchronous, active-low.
  - DMA state IDLE, dma_page=0x00, idx=0, phase=0, dma_byte=0.
  - All strobes (src_rd, vram_*/oam_* rd/wr) 0; addresses and wdata 0; dma_active 0.
  - Read-data outputs are combinational: 0xFF when not granted.
- DMA FSM: IDLE -> START -> XFER -> IDLE.
  - cpu_wr to 0xFF46 latches dma_page=cpu_wdata and enters START. This applies from any state, so a rewrite restarts the transfer with idx=0 and phase=0.
  - START lasts 1 cycle with no transfers. dma_active goes high on entry to START.
  - XFER, phase 0: src_rd=1, src_addr={eff_page, idx}, dma_byte<=src_rdata.
  - XFER, phase CYC_PER_BYTE-1: oam_wr=1, oam_addr=idx, oam_wdata=dma_byte, idx++.
  - Phase wraps at CYC_PER_BYTE.
  - After write of idx=DMA_BYTES-1: go to IDLE; dma_active drops the next cycle.
  - Total: 1 + DMA_BYTES*CYC_PER_BYTE cycles from the trigger edge (641 by default).
- eff_page = dma_page ≥ 0xE0 ? dma_page−0x20 : dma_page (echo-RAM fold).
- cpu_rdata at 0xFF46 returns dma_page.
- OAM grant, priority DMA > PPU > CPU:
  - dma_active: CPU reads of OAM return 0xFF and CPU writes are dropped. PPU OAM reads return 0xFF. oam_rd=0 except DMA cycles.
  - Else if lcd_on and ppu_mode∈{2,3}: PPU owns OAM. CPU reads 0xFF, writes dropped.
  - Else: CPU owns OAM. PPU reads return 0xFF.
- VRAM grant:
  - lcd_on and ppu_mode==3: PPU owns VRAM. CPU reads 0xFF, writes dropped.
  - Else: CPU owns VRAM; PPU reads return 0xFF.
  - DMA never touches VRAM ports. A VRAM source page is read via src_* externally.
- Address decode:
  - OAM hit = addr in [0xFE00, 0xFE9F].
  - 0xFEA0–0xFEFF: reads 0xFF, writes ignored, no strobe.
  - VRAM hit = addr[15:13]==3'b100; vram_addr = addr[12:0]; oam_addr = addr[7:0].
- Port drive:
  - Port strobes are combinational from the grant and the requester strobe.
  - The DMA OAM write is combinational from FSM state.
  - Read data is combinational from the RAM.
- Simultaneous events:
  - CPU write to 0xFF46 on a DMA write phase: the current OAM write still happens, then restart.
  - Mode change mid-cycle: the grant follows the current ppu_mode with no latching.
- Reset mid-DMA aborts immediately: no further oam_wr, dma_active=0.

Test Plan:
- Idle, lcd_on=0: CPU writes 0x5A to 0x8010, reads back -> vram_wr at offset 0x010 and cpu_rdata=0x5A; CPU write to 0xFE05 -> oam_wr at oam_addr=0x05.
- lcd_on=1, ppu_mode=3: CPU reads 0x9800 and 0xFE00 -> cpu_rdata=0xFF, no vram_rd/oam_rd; ppu_rd at 0x9800 -> ppu_rdata=vram_rdata.
- Write 0xC1 to 0xFF46 with src returning low address byte -> dma_active high for 641 cycles; 160 oam_wr with oam_wdata=idx; src_addr 0xC100..0xC19F.
- During DMA, CPU reads 0xFE10 and PPU reads OAM in mode 2 -> both get 0xFF, no CPU oam_wr.
- Write 0xFE to 0xFF46 -> src_addr starts 0xDE00; at idx=50 rewrite 0x80 -> restart, src_addr 0x8000, idx=0, total 160 fresh writes.
- Assert rstN low at idx=100 -> dma_active=0 and strobes 0 immediately; no oam_wr after release.
